// File: rtl/ibex_xif_icache_maint_pkg.sv
// rtl/ibex_xif_icache_maint_pkg.sv - shared types for the icache maintenance sequencer
package ibex_xif_icache_maint_pkg;

    localparam int unsigned INV_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BOOT     = 3'd1,
        RUN      = 3'd2,
        INV      = 3'd3,
        INV_WAIT = 3'd4,
        REDIRECT = 3'd5
    } maint_state_e;

endpackage

// File: rtl/ibex_xif_icache_maint_ctrl_timer.sv
// rtl/ibex_xif_icache_maint_ctrl_timer.sv - loadable saturating down-counter with zero flag
module ibex_xif_icache_maint_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/ibex_xif_icache_maint_ctrl.sv
// rtl/ibex_xif_icache_maint_ctrl.sv - icache boot/enable/fence.i sequencer; optional ICACHE_MAINT_TIMEOUT_EN watchdog
module ibex_xif_icache_maint_ctrl
    import ibex_xif_icache_maint_pkg::*;
#(
    parameter int unsigned INV_CYCLES     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en_i,
    input  logic [31:0] boot_addr_i,
    input  logic        csr_icache_en_i,
    input  logic        fence_req_i,
    input  logic [31:0] fence_pc_i,
    output logic        fence_ack_o,
    input  logic        busy_i,
    output logic        req_o,
    output logic        branch_o,
    output logic [31:0] branch_addr_o,
    output logic        enable_o,
    output logic        invalidate_o,
    output logic        ctrl_busy_o
`ifdef ICACHE_MAINT_TIMEOUT_EN
    ,
    output logic        timeout_err_o
`endif
);

    maint_state_e state_q, state_d;
    logic         fence_accept;
    logic         inv_zero;
    logic         wd_expired;
    logic [31:0]  fence_pc_q;

    ibex_xif_icache_maint_timer #(.W(INV_CNT_W)) u_inv_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (fence_accept),
        .load_val (INV_CNT_W'(INV_CYCLES - 1)),
        .dec      (state_q == INV),
        .zero     (inv_zero)
    );

`ifdef ICACHE_MAINT_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic wd_zero;

    // Armed as the invalidate pulse ends; counts only cycles where the cache is still busy.
    ibex_xif_icache_maint_timer #(.W(WD_W)) u_wd_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     ((state_q == INV) && inv_zero),
        .load_val (WD_W'(TIMEOUT_CYCLES - 1)),
        .dec      ((state_q == INV_WAIT) && busy_i),
        .zero     (wd_zero)
    );

    assign wd_expired = (state_q == INV_WAIT) && busy_i && wd_zero;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_err_o <= 1'b0;
        end else if (wd_expired) begin
            timeout_err_o <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign wd_expired         = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        fence_accept = 1'b0;
        case (state_q)
            IDLE:     if (fetch_en_i) state_d = BOOT;
            BOOT:     state_d = RUN;
            RUN: begin
                if (!fetch_en_i) begin
                    state_d = IDLE;
                end else if (fence_req_i && !fence_ack_o) begin
                    state_d      = INV;
                    fence_accept = 1'b1;
                end
            end
            INV:      if (inv_zero) state_d = INV_WAIT;
            INV_WAIT: if (!busy_i || wd_expired) state_d = REDIRECT;
            REDIRECT: state_d = fetch_en_i ? RUN : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fence_pc_q    <= '0;
            req_o         <= 1'b0;
            branch_o      <= 1'b0;
            branch_addr_o <= '0;
            enable_o      <= 1'b0;
            invalidate_o  <= 1'b0;
            fence_ack_o   <= 1'b0;
            ctrl_busy_o   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_o        <= (state_d == BOOT) || (state_d == REDIRECT) ||
                            ((state_d == RUN) && fetch_en_i);
            branch_o     <= (state_d == BOOT) || (state_d == REDIRECT);
            invalidate_o <= (state_d == INV);
            fence_ack_o  <= (state_d == REDIRECT);
            ctrl_busy_o  <= (state_d != RUN) && (state_d != IDLE);
            // CSR enable is frozen outside RUN; the entry edge into RUN picks up the latest value.
            if (state_d == RUN) begin
                enable_o <= csr_icache_en_i;
            end
            if (state_d == BOOT) begin
                branch_addr_o <= boot_addr_i;
            end else if (state_d == REDIRECT) begin
                branch_addr_o <= fence_pc_q;
            end
            if (fence_accept) begin
                fence_pc_q <= fence_pc_i;
            end
        end
    end

endmodule

// File: tb/tb_ibex_xif_icache_maint_ctrl.sv
// tb/tb_ibex_xif_icache_maint_ctrl.sv - scoreboard bench for ibex_xif_icache_maint_ctrl
module tb_ibex_xif_icache_maint_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en_i;
    logic [31:0] boot_addr_i;
    logic        csr_icache_en_i;
    logic        fence_req_i;
    logic [31:0] fence_pc_i;
    logic        fence_ack_o;
    logic        busy_i;
    logic        req_o;
    logic        branch_o;
    logic [31:0] branch_addr_o;
    logic        enable_o;
    logic        invalidate_o;
    logic        ctrl_busy_o;
    logic        terr_act;

`ifdef ICACHE_MAINT_TIMEOUT_EN
    localparam int BUSY_HOLD = 6;
    logic timeout_err_o;
    assign terr_act = timeout_err_o;
`else
    localparam int BUSY_HOLD = 10;
    assign terr_act = 1'b0;
`endif

    ibex_xif_icache_maint_ctrl #(.INV_CYCLES(3), .TIMEOUT_CYCLES(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_en_i      (fetch_en_i),
        .boot_addr_i     (boot_addr_i),
        .csr_icache_en_i (csr_icache_en_i),
        .fence_req_i     (fence_req_i),
        .fence_pc_i      (fence_pc_i),
        .fence_ack_o     (fence_ack_o),
        .busy_i          (busy_i),
        .req_o           (req_o),
        .branch_o        (branch_o),
        .branch_addr_o   (branch_addr_o),
        .enable_o        (enable_o),
        .invalidate_o    (invalidate_o),
        .ctrl_busy_o     (ctrl_busy_o)
`ifdef ICACHE_MAINT_TIMEOUT_EN
        ,
        .timeout_err_o   (timeout_err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [6:0]  flags;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic exp_terr    = 1'b0;

    task automatic push_exp(input string name, input logic req, input logic br,
                            input logic [31:0] addr, input logic en, input logic inv,
                            input logic ack, input logic cb);
        exp_t e;
        e.name  = name;
        e.flags = {req, br, en, inv, ack, cb, exp_terr};
        e.addr  = addr;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t       e;
        logic [6:0] act;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {req_o, branch_o, enable_o, invalidate_o, fence_ack_o, ctrl_busy_o, terr_act};
            vectors++;
            if (act !== e.flags || branch_addr_o !== e.addr) begin
                miscompares++;
                $display("FAIL %s: req,br,en,inv,ack,busy,terr got %b want %b; addr got %h want %h",
                         e.name, act, e.flags, branch_addr_o, e.addr);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_en_i = 1'b0; boot_addr_i = '0; csr_icache_en_i = 1'b0;
        fence_req_i = 1'b0; fence_pc_i = '0; busy_i = 1'b0;
        push_exp("reset", 0, 0, 32'h0, 0, 0, 0, 0); tick();
        rst_n = 1'b1;
        push_exp("idle", 0, 0, 32'h0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_boot();
        boot_addr_i = 32'h80; fetch_en_i = 1'b1;
        push_exp("boot_branch", 1, 1, 32'h80, 0, 0, 0, 1); tick();
        boot_addr_i = 32'hdead_beef;
        push_exp("boot_run", 1, 0, 32'h80, 0, 0, 0, 0); tick();
        push_exp("run_hold", 1, 0, 32'h80, 0, 0, 0, 0); tick();
    endtask

    task automatic test_csr_run();
        csr_icache_en_i = 1'b1;
        push_exp("csr_on", 1, 0, 32'h80, 1, 0, 0, 0); tick();
        csr_icache_en_i = 1'b0;
        push_exp("csr_off", 1, 0, 32'h80, 0, 0, 0, 0); tick();
    endtask

    task automatic test_fence();
        fence_req_i = 1'b1; fence_pc_i = 32'h1004;
        push_exp("fence_inv1", 0, 0, 32'h80, 0, 1, 0, 1); tick();
        fence_pc_i = 32'hffff_fff0;
        push_exp("fence_inv2", 0, 0, 32'h80, 0, 1, 0, 1); tick();
        push_exp("fence_inv3", 0, 0, 32'h80, 0, 1, 0, 1); tick();
        push_exp("fence_wait", 0, 0, 32'h80, 0, 0, 0, 1); tick();
        push_exp("fence_redirect", 1, 1, 32'h1004, 0, 0, 1, 1); tick();
        fence_req_i = 1'b0;
        push_exp("fence_run", 1, 0, 32'h1004, 0, 0, 0, 0); tick();
    endtask

    task automatic test_busy_hold();
        fence_req_i = 1'b1; fence_pc_i = 32'h2000; busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_exp("busy_inv", 0, 0, 32'h1004, 0, 1, 0, 1); tick();
        end
        for (int i = 0; i <= BUSY_HOLD; i++) begin
            push_exp("busy_wait", 0, 0, 32'h1004, 0, 0, 0, 1); tick();
        end
        busy_i = 1'b0;
        push_exp("busy_redirect", 1, 1, 32'h2000, 0, 0, 1, 1); tick();
        fence_req_i = 1'b0;
        push_exp("busy_run", 1, 0, 32'h2000, 0, 0, 0, 0); tick();
    endtask

    task automatic test_csr_during_fence();
        fence_req_i = 1'b1; fence_pc_i = 32'h3000;
        push_exp("csrf_inv1", 0, 0, 32'h2000, 0, 1, 0, 1); tick();
        csr_icache_en_i = 1'b1;
        push_exp("csrf_inv2", 0, 0, 32'h2000, 0, 1, 0, 1); tick();
        push_exp("csrf_inv3", 0, 0, 32'h2000, 0, 1, 0, 1); tick();
        push_exp("csrf_wait", 0, 0, 32'h2000, 0, 0, 0, 1); tick();
        push_exp("csrf_redirect", 1, 1, 32'h3000, 0, 0, 1, 1); tick();
        fence_req_i = 1'b0;
        push_exp("csrf_run_en", 1, 0, 32'h3000, 1, 0, 0, 0); tick();
        csr_icache_en_i = 1'b0;
        push_exp("csrf_run_dis", 1, 0, 32'h3000, 0, 0, 0, 0); tick();
    endtask

    task automatic test_fetch_drop_fence();
        fence_req_i = 1'b1; fence_pc_i = 32'h4000;
        push_exp("drop_inv1", 0, 0, 32'h3000, 0, 1, 0, 1); tick();
        fetch_en_i = 1'b0;
        push_exp("drop_inv2", 0, 0, 32'h3000, 0, 1, 0, 1); tick();
        push_exp("drop_inv3", 0, 0, 32'h3000, 0, 1, 0, 1); tick();
        push_exp("drop_wait", 0, 0, 32'h3000, 0, 0, 0, 1); tick();
        push_exp("drop_redirect", 1, 1, 32'h4000, 0, 0, 1, 1); tick();
        fence_req_i = 1'b0;
        push_exp("drop_idle", 0, 0, 32'h4000, 0, 0, 0, 0); tick();
        push_exp("drop_idle2", 0, 0, 32'h4000, 0, 0, 0, 0); tick();
    endtask

    task automatic test_boot_priority();
        boot_addr_i = 32'h100; fetch_en_i = 1'b1; fence_req_i = 1'b1; fence_pc_i = 32'h5000;
        push_exp("prio_boot", 1, 1, 32'h100, 0, 0, 0, 1); tick();
        push_exp("prio_run", 1, 0, 32'h100, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            push_exp("prio_inv", 0, 0, 32'h100, 0, 1, 0, 1); tick();
        end
        push_exp("prio_wait", 0, 0, 32'h100, 0, 0, 0, 1); tick();
        push_exp("prio_redirect", 1, 1, 32'h5000, 0, 0, 1, 1); tick();
        fence_req_i = 1'b0;
        push_exp("prio_run2", 1, 0, 32'h5000, 0, 0, 0, 0); tick();
    endtask

    task automatic test_fetch_drop_run();
        fetch_en_i = 1'b0;
        push_exp("run_drop_idle", 0, 0, 32'h5000, 0, 0, 0, 0); tick();
        fetch_en_i = 1'b1; boot_addr_i = 32'h80;
        push_exp("reboot", 1, 1, 32'h80, 0, 0, 0, 1); tick();
        push_exp("reboot_run", 1, 0, 32'h80, 0, 0, 0, 0); tick();
    endtask

    task automatic test_reset_mid_inv();
        csr_icache_en_i = 1'b1;
        push_exp("rst_pre_en", 1, 0, 32'h80, 1, 0, 0, 0); tick();
        fence_req_i = 1'b1; fence_pc_i = 32'h6000;
        push_exp("rst_inv1", 0, 0, 32'h80, 1, 1, 0, 1); tick();
        rst_n = 1'b0;
        push_exp("rst_mid_inv", 0, 0, 32'h0, 0, 0, 0, 0); tick();
        rst_n = 1'b1; fetch_en_i = 1'b0; fence_req_i = 1'b0; csr_icache_en_i = 1'b0;
        push_exp("rst_idle", 0, 0, 32'h0, 0, 0, 0, 0); tick();
        push_exp("rst_no_ack", 0, 0, 32'h0, 0, 0, 0, 0); tick();
        fetch_en_i = 1'b1;
        push_exp("rst_boot", 1, 1, 32'h80, 0, 0, 0, 1); tick();
        push_exp("rst_run", 1, 0, 32'h80, 0, 0, 0, 0); tick();
    endtask

`ifdef ICACHE_MAINT_TIMEOUT_EN
    task automatic test_timeout();
        fence_req_i = 1'b1; fence_pc_i = 32'h7000; busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_exp("to_inv", 0, 0, 32'h80, 0, 1, 0, 1); tick();
        end
        for (int i = 0; i < 8; i++) begin
            push_exp("to_wait", 0, 0, 32'h80, 0, 0, 0, 1); tick();
        end
        exp_terr = 1'b1;
        push_exp("to_redirect", 1, 1, 32'h7000, 0, 0, 1, 1); tick();
        busy_i = 1'b0; fence_req_i = 1'b0;
        push_exp("to_run", 1, 0, 32'h7000, 0, 0, 0, 0); tick();
        push_exp("to_sticky", 1, 0, 32'h7000, 0, 0, 0, 0); tick();
    endtask
`endif

    initial begin
        test_reset();
        test_boot();
        test_csr_run();
        test_fence();
        test_busy_hold();
        test_csr_during_fence();
        test_fetch_drop_fence();
        test_boot_priority();
        test_fetch_drop_run();
        test_reset_mid_inv();
`ifdef ICACHE_MAINT_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule
